// File: rtl/instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// instr_fetch_unit
//
// Instruction fetch front end of the multicycle RISC-V core. Owns the PC,
// drives the instruction ROM address, captures the ROM's registered read data
// into the instruction register and offers it to the core control FSM with a
// valid/ready handshake. Branch/jump/trap redirects reload the PC; a redirect
// to a non-word-aligned target raises a sticky fault that only reset clears.
//
// Ports:
//   clk          core clock, rising edge
//   rst_n        asynchronous active-low reset
//   fetch_en     permits new fetches to start
//   rom_addr     registered byte address to the instruction ROM
//   rom_data     ROM read data, valid one clock after the ROM samples rom_addr
//   ir           captured instruction
//   ir_pc        PC of the instruction held in ir
//   ir_valid     ir/ir_pc hold a valid instruction
//   ir_ready     core accepts ir this cycle
//   redirect     load a new PC from redirect_pc
//   redirect_pc  redirect target PC
//   fault        sticky misaligned-redirect flag
//   fetch_count  number of accepted instructions (wraps at 2^32)
// ----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int          ADDR_W   = 14,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_data,
  output logic [31:0]       ir,
  output logic [31:0]       ir_pc,
  output logic              ir_valid,
  input  logic              ir_ready,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  output logic              fault,
  output logic [31:0]       fetch_count
);

  // S_ISSUE : rom_addr is stable, the ROM samples it at the closing edge
  // S_CAPTURE: rom_data is valid, captured into ir at the closing edge
  // S_HOLD  : ir is presented until the core accepts it
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2,
    S_HOLD    = 2'd3
  } state_t;

  state_t state_reg;
  state_t state_next;

  logic [31:0]       pc_reg;
  logic [31:0]       pc_next;
  logic [ADDR_W-1:0] rom_addr_reg;
  logic [31:0]       ir_reg;
  logic [31:0]       ir_pc_reg;
  logic              ir_valid_reg;
  logic              fault_reg;
  logic [31:0]       fetch_count_reg;

  // Per-cycle control strobes
  logic redir_ok;   // aligned redirect, takes effect this edge
  logic redir_bad;  // misaligned redirect, raises the fault
  logic accept;     // handshake completes this edge
  logic capture;    // rom_data is loaded into ir this edge

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic. A raised fault pins the FSM in S_IDLE and masks every
  // input; a redirect overrides the normal sequence from any state.
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    if (fault_reg || redir_bad) begin
      state_next = S_IDLE;
    end else if (redir_ok) begin
      state_next = fetch_en ? S_ISSUE : S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE:    if (fetch_en) state_next = S_ISSUE;
        S_ISSUE:   state_next = S_CAPTURE;
        S_CAPTURE: state_next = S_HOLD;
        S_HOLD:    if (ir_ready) state_next = fetch_en ? S_ISSUE : S_IDLE;
        default:   state_next = S_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Output/control decode from the current state and inputs.
  // --------------------------------------------------------------------------
  always_comb begin
    redir_ok  = 1'b0;
    redir_bad = 1'b0;
    accept    = 1'b0;
    capture   = 1'b0;
    if (!fault_reg) begin
      if (redirect) begin
        redir_ok  = (redirect_pc[1:0] == 2'b00);
        redir_bad = (redirect_pc[1:0] != 2'b00);
      end
      // The handshake still completes when a redirect arrives in the same
      // cycle; only the following PC changes.
      accept  = (state_reg == S_HOLD) && ir_ready;
      // Any redirect during S_CAPTURE discards the in-flight ROM word.
      capture = (state_reg == S_CAPTURE) && !redirect;
    end
  end

  // Redirect target wins over the sequential increment (32-bit wrap).
  always_comb begin
    pc_next = pc_reg;
    if (redir_ok) begin
      pc_next = redirect_pc;
    end else if (accept) begin
      pc_next = pc_reg + 32'd4;
    end
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg          <= RESET_PC;
      rom_addr_reg    <= RESET_PC[ADDR_W-1:0];
      ir_reg          <= 32'd0;
      ir_pc_reg       <= 32'd0;
      ir_valid_reg    <= 1'b0;
      fault_reg       <= 1'b0;
      fetch_count_reg <= 32'd0;
    end else begin
      pc_reg <= pc_next;

      // rom_addr only moves on entry to S_ISSUE, so it stays pinned to the
      // pending or held fetch for the whole issue/capture/hold sequence.
      if (state_next == S_ISSUE) begin
        rom_addr_reg <= pc_next[ADDR_W-1:0];
      end

      if (capture) begin
        ir_reg    <= rom_data;
        ir_pc_reg <= pc_reg;
      end

      if (capture) begin
        ir_valid_reg <= 1'b1;
      end else if (accept || redir_ok || redir_bad) begin
        ir_valid_reg <= 1'b0;
      end

      if (accept) begin
        fetch_count_reg <= fetch_count_reg + 32'd1;
      end

      if (redir_bad) begin
        fault_reg <= 1'b1;
      end
    end
  end

  assign rom_addr    = rom_addr_reg;
  assign ir          = ir_reg;
  assign ir_pc       = ir_pc_reg;
  assign ir_valid    = ir_valid_reg;
  assign fault       = fault_reg;
  assign fetch_count = fetch_count_reg;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Drives instr_fetch_unit against a registered ROM model. A table of fetch
// records (stall length, redirect kind, expected instruction/PC/latency) is
// walked in a loop; expected instructions are pushed to a scoreboard queue as
// each fetch is started and popped by a monitor when the core-side handshake
// completes. Hand-written sequences cover the misaligned fault, reset while
// issuing and fetch_en deassertion.
// ----------------------------------------------------------------------------
module tb_instr_fetch_unit;

  localparam int ADDR_W = 14;
  localparam int K_NONE = 0;  // plain accept
  localparam int K_ACC  = 1;  // redirect in the same cycle as the accept
  localparam int K_CAP  = 2;  // redirect during S_CAPTURE of the next fetch

  logic              clk = 1'b0;
  logic              rst_n;
  logic              fetch_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [31:0]       rom_data;
  logic [31:0]       ir;
  logic [31:0]       ir_pc;
  logic              ir_valid;
  logic              ir_ready;
  logic              redirect;
  logic [31:0]       redirect_pc;
  logic              fault;
  logic [31:0]       fetch_count;

  instr_fetch_unit #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_en    (fetch_en),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .ir          (ir),
    .ir_pc       (ir_pc),
    .ir_valid    (ir_valid),
    .ir_ready    (ir_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .fault       (fault),
    .fetch_count (fetch_count)
  );

  always #5 clk = ~clk;

  // Registered-output ROM: data for the address sampled at one edge is
  // visible after that edge.
  logic [31:0] rom_mem [0:4095];
  always @(posedge clk) rom_data <= rom_mem[rom_addr[ADDR_W-1:2]];

  int          n_cmp = 0;
  int          n_err = 0;
  int          model_count;
  logic [63:0] exp_q[$];

  typedef struct {
    int          stall;
    int          kind;
    logic [31:0] tgt;
    logic [31:0] exp_ir;
    logic [31:0] exp_pc;
    int          exp_lat;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ir"}, ir, 32'd0);
    chk({tag, "_ir_pc"}, ir_pc, 32'd0);
    chk({tag, "_ir_valid"}, {31'd0, ir_valid}, 32'd0);
    chk({tag, "_fault"}, {31'd0, fault}, 32'd0);
    chk({tag, "_fetch_count"}, fetch_count, 32'd0);
    chk({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
  endtask

  // Scoreboard monitor: compares the presented instruction at each accept.
  always @(negedge clk) begin
    logic [63:0] e;
    if (rst_n === 1'b1 && ir_valid === 1'b1 && ir_ready === 1'b1) begin
      $display("accept ir_pc=%h ir=%h rom_addr=%h", ir_pc, ir, rom_addr);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_empty: got ir_pc=%h ir=%h expected no transaction", ir_pc, ir);
      end else begin
        e = exp_q.pop_front();
        chk("sb_ir", ir, e[63:32]);
        chk("sb_ir_pc", ir_pc, e[31:0]);
        chk("sb_rom_addr", 32'(rom_addr), e[31:0] & 32'h0000_3FFF);
      end
    end
  end

  // One fetch: wait for ir_valid (bounded), stall while checking the held
  // values, then accept, optionally combined with a redirect.
  task automatic fetch_one(input int stall, input int kind, input logic [31:0] tgt,
                           input logic [31:0] exp_ir, input logic [31:0] exp_pc,
                           input int exp_lat);
    int lat;
    exp_q.push_back({exp_ir, exp_pc});
    lat = 0;
    while (ir_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    if (ir_valid !== 1'b1) begin
      void'(exp_q.pop_back());
    end else begin
      for (int s = 0; s < stall; s++) begin
        chk("hold_ir", ir, exp_ir);
        chk("hold_ir_pc", ir_pc, exp_pc);
        chk("hold_valid", {31'd0, ir_valid}, 32'd1);
        chk("hold_rom_addr", 32'(rom_addr), exp_pc & 32'h0000_3FFF);
        @(posedge clk); #1;
      end
      ir_ready = 1'b1;
      if (kind == K_ACC) begin
        redirect    = 1'b1;
        redirect_pc = tgt;
      end
      @(posedge clk); #1;
      ir_ready = 1'b0;
      redirect = 1'b0;
      model_count++;
      chk("fetch_count", fetch_count, 32'(model_count));
      chk("valid_after_accept", {31'd0, ir_valid}, 32'd0);
      if (kind == K_CAP) begin
        @(posedge clk); #1;
        chk("cap_rom_addr", 32'(rom_addr), (exp_pc + 32'd4) & 32'h0000_3FFF);
        chk("cap_valid", {31'd0, ir_valid}, 32'd0);
        redirect    = 1'b1;
        redirect_pc = tgt;
        @(posedge clk); #1;
        redirect = 1'b0;
        chk("cap_suppressed", {31'd0, ir_valid}, 32'd0);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4096; i++) rom_mem[i] = 32'd0;
    rom_mem[0]    = 32'h0010_0093;
    rom_mem[1]    = 32'h0000_9f13;
    rom_mem[2]    = 32'h0050_0113;
    rom_mem[4]    = 32'h0020_8233;
    rom_mem[160]  = 32'h0030_1863;  // 0x280
    rom_mem[4095] = 32'h0bad_c0de;  // 0x3FFC

    //          stall kind    target          exp_ir          exp_pc          lat
    vecs[0] = '{5, K_NONE, 32'h0,           32'h0010_0093, 32'h0000_0000, 3};
    vecs[1] = '{0, K_CAP,  32'h0000_0280,   32'h0000_9f13, 32'h0000_0004, 2};
    vecs[2] = '{2, K_ACC,  32'h0000_02A4,   32'h0030_1863, 32'h0000_0280, 2};
    vecs[3] = '{1, K_ACC,  32'h0000_0010,   32'h0000_0000, 32'h0000_02A4, 2};
    vecs[4] = '{0, K_ACC,  32'h0001_0010,   32'h0020_8233, 32'h0000_0010, 2};
    vecs[5] = '{0, K_ACC,  32'hFFFF_FFFC,   32'h0020_8233, 32'h0001_0010, 2};
    vecs[6] = '{3, K_NONE, 32'h0,           32'h0bad_c0de, 32'hFFFF_FFFC, 2};
    vecs[7] = '{0, K_NONE, 32'h0,           32'h0010_0093, 32'h0000_0000, 2};
    vecs[8] = '{0, K_NONE, 32'h0,           32'h0000_9f13, 32'h0000_0004, 2};

    rst_n       = 1'b0;
    fetch_en    = 1'b0;
    ir_ready    = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    rom_data    = 32'd0;
    model_count = 0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("por");

    rst_n    = 1'b1;
    fetch_en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      fetch_one(vecs[i].stall, vecs[i].kind, vecs[i].tgt,
                vecs[i].exp_ir, vecs[i].exp_pc, vecs[i].exp_lat);
    end

    // Misaligned redirect while issuing PC 8: sticky fault, FSM parks idle.
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0282;
    @(posedge clk); #1;
    redirect = 1'b0;
    chk("mis_fault", {31'd0, fault}, 32'd1);
    chk("mis_valid", {31'd0, ir_valid}, 32'd0);
    redirect    = 1'b1;          // must be ignored while faulted
    redirect_pc = 32'h0000_0010;
    @(posedge clk); #1;
    redirect = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("mis_idle_valid", {31'd0, ir_valid}, 32'd0);
      chk("mis_idle_rom_addr", 32'(rom_addr), 32'h0000_0008);
      chk("mis_idle_fault", {31'd0, fault}, 32'd1);
      @(posedge clk); #1;
    end
    chk("mis_count", fetch_count, 32'(model_count));

    // Reset pulse clears the fault; fetching resumes at PC 0.
    rst_n = 1'b0;
    #1;
    check_reset_vals("rst_fault");
    @(posedge clk); #1;
    rst_n       = 1'b1;
    model_count = 0;
    fetch_one(0, K_NONE, 32'h0, 32'h0010_0093, 32'h0000_0000, 3);

    // Reset asserted while issuing PC 4: asynchronous return to reset values.
    rst_n = 1'b0;
    #1;
    check_reset_vals("rst_issue");
    @(posedge clk); #1;
    rst_n       = 1'b1;
    model_count = 0;
    fetch_one(0, K_NONE, 32'h0, 32'h0010_0093, 32'h0000_0000, 3);

    // fetch_en dropped mid-fetch: in-flight PC 4 completes, nothing follows.
    fetch_en = 1'b0;
    fetch_one(2, K_NONE, 32'h0, 32'h0000_9f13, 32'h0000_0004, 2);
    for (int i = 0; i < 5; i++) begin
      chk("noen_valid", {31'd0, ir_valid}, 32'd0);
      chk("noen_rom_addr", 32'(rom_addr), 32'h0000_0004);
      @(posedge clk); #1;
    end
    chk("noen_count", fetch_count, 32'd2);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
